// File: rtl/carry_lookahead_adder_8b.sv
// 8-bit two-level carry-lookahead adder with registered {carry, sum}.
// Optional signed overflow output enabled by defining CLA_OVERFLOW_EN.

module cla_group4 (
  input  logic [3:0] i_g,
  input  logic [3:0] i_p,
  input  logic       i_c,
  output logic [3:0] o_c,
  output logic       o_gg,
  output logic       o_gp
);
  // Every carry is flattened from the group's carry-in, so no carry feeds the next one.
  assign o_c[0] = i_c;
  assign o_c[1] = i_g[0] | (i_p[0] & i_c);
  assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                | (i_p[2] & i_p[1] & i_p[0] & i_c);
  assign o_gg   = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
  assign o_gp   = &i_p;
endmodule

module carry_lookahead_adder_8b (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  input  logic       iCarryIn,
`ifdef CLA_OVERFLOW_EN
  output logic       oOverflow,
`endif
  output logic [7:0] oSum,
  output logic       oCarry
);
  logic [7:0] w_g, w_p, w_c;
  logic [1:0] w_gg, w_gp;
  logic       w_c4, w_c8;
  logic [7:0] r_sum;
  logic       r_carry;

  assign w_g = iA & iB;
  assign w_p = iA ^ iB;

  cla_group4 u_grp0 (
    .i_g (w_g[3:0]),
    .i_p (w_p[3:0]),
    .i_c (iCarryIn),
    .o_c (w_c[3:0]),
    .o_gg(w_gg[0]),
    .o_gp(w_gp[0])
  );

  cla_group4 u_grp1 (
    .i_g (w_g[7:4]),
    .i_p (w_p[7:4]),
    .i_c (w_c4),
    .o_c (w_c[7:4]),
    .o_gg(w_gg[1]),
    .o_gp(w_gp[1])
  );

  // Second lookahead level: group carries straight from G/P and c0.
  assign w_c4 = w_gg[0] | (w_gp[0] & iCarryIn);
  assign w_c8 = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & iCarryIn);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_sum   <= 8'h00;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_p ^ w_c;
      r_carry <= w_c8;
    end
  end

  assign oSum   = r_sum;
  assign oCarry = r_carry;

`ifdef CLA_OVERFLOW_EN
  logic r_ovf;
  always_ff @(posedge iClk) begin
    if (iRst) r_ovf <= 1'b0;
    else      r_ovf <= w_c8 ^ w_c[7];
  end
  assign oOverflow = r_ovf;
`endif
endmodule

// File: tb/tb_carry_lookahead_adder_8b.sv
// Directed-vector and random bench for carry_lookahead_adder_8b.
// Build with CLA_OVERFLOW_EN defined to also check the overflow flag.

module tb_carry_lookahead_adder_8b;
  logic       iClk = 1'b0;
  logic       iRst;
  logic [7:0] iA, iB;
  logic       iCarryIn;
  logic [7:0] oSum;
  logic       oCarry;
`ifdef CLA_OVERFLOW_EN
  logic       oOverflow;
`endif

  int checks   = 0;
  int failures = 0;

  carry_lookahead_adder_8b dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iA       (iA),
    .iB       (iB),
    .iCarryIn (iCarryIn),
`ifdef CLA_OVERFLOW_EN
    .oOverflow(oOverflow),
`endif
    .oSum     (oSum),
    .oCarry   (oCarry)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [8:0] exp;
  } vec_t;

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%03h) expected %0d (0x%03h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one operand set, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic [7:0] a, input logic [7:0] b, input logic ci);
    iRst = rst; iA = a; iB = b; iCarryIn = ci;
    @(posedge iClk);
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_sum;

    vecs[0] = '{8'd10,  8'd20,  1'b0, 9'd30};
    vecs[1] = '{8'd100, 8'd27,  1'b1, 9'd128};
    vecs[2] = '{8'hFF,  8'h00,  1'b1, 9'h100};
    vecs[3] = '{8'h0F,  8'h00,  1'b1, 9'h010};
    vecs[4] = '{8'hFF,  8'hFF,  1'b1, 9'h1FF};
    vecs[5] = '{8'h00,  8'h00,  1'b0, 9'h000};
    vecs[6] = '{8'hF0,  8'h10,  1'b0, 9'h100};
    vecs[7] = '{8'h55,  8'hAA,  1'b1, 9'h100};

    // Reset dominates even with all-ones operands
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    check9("reset_edge1", {oCarry, oSum}, 9'h000);
    step(1'b1, 8'hFF, 8'hFF, 1'b1);
    check9("reset_edge2", {oCarry, oSum}, 9'h000);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].a, vecs[i].b, vecs[i].ci);
      check9($sformatf("vec%0d", i), {oCarry, oSum}, vecs[i].exp);
    end

    // Back-to-back max then zero: nothing carries across cycles
    step(1'b0, 8'hFF, 8'hFF, 1'b1);
    check9("b2b_max", {oCarry, oSum}, 9'd511);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check9("b2b_zero", {oCarry, oSum}, 9'd0);

    // Output holds between edges
    iA = 8'h33; iB = 8'h44; iCarryIn = 1'b1;
    #3;
    check9("hold_between_edges", {oCarry, oSum}, 9'd0);

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      step(1'b0, ra, rb, rc);
      check9($sformatf("rand%0d", i), {oCarry, oSum}, ref_sum);
    end

    // Mid-stream reset for one cycle, then results resume
    step(1'b0, 8'hC8, 8'h64, 1'b1);
    check9("pre_rst", {oCarry, oSum}, 9'd301);
    step(1'b1, 8'hEE, 8'h99, 1'b1);
    check9("mid_rst", {oCarry, oSum}, 9'd0);
    step(1'b0, 8'h81, 8'h7F, 1'b0);
    check9("post_rst", {oCarry, oSum}, 9'd256);

`ifdef CLA_OVERFLOW_EN
    step(1'b0, 8'h7F, 8'h01, 1'b0);
    check9("ovf_7f_01", {oCarry, oSum}, 9'h080);
    check9("ovf_7f_01_flag", {8'h00, oOverflow}, 9'd1);
    step(1'b0, 8'h80, 8'h80, 1'b0);
    check9("ovf_80_80", {oCarry, oSum}, 9'h100);
    check9("ovf_80_80_flag", {8'h00, oOverflow}, 9'd1);
    step(1'b0, 8'hFF, 8'h01, 1'b0);
    check9("ovf_ff_01_flag", {8'h00, oOverflow}, 9'd0);
    step(1'b1, 8'h7F, 8'h01, 1'b0);
    check9("ovf_reset_flag", {8'h00, oOverflow}, 9'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
